// File: rtl/mempool_pkg.sv
// +--------------------------------------------------------------------------+
// | mempool_pkg: shared TCDM types and constants for the bank responder.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package mempool_pkg;

  localparam int unsigned NumBanksPerTile = 16;
  localparam int unsigned DataWidth       = 32;
  localparam int unsigned BeWidth         = DataWidth / 8;
  localparam int unsigned TgtAddrWidth    = 12;
  localparam int unsigned MetaIdWidth     = 8;
  localparam int unsigned CoreIdWidth     = 4;
  localparam int unsigned IniAddrWidth    = 4;
  localparam int unsigned AmoWidth        = 4;

  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

  localparam int unsigned BankIdxWidth  = idx_width(NumBanksPerTile);
  localparam int unsigned BankAddrWidth = TgtAddrWidth - BankIdxWidth;

  typedef logic [DataWidth-1:0]     data_t;
  typedef logic [BeWidth-1:0]       strb_t;
  typedef logic [TgtAddrWidth-1:0]  tgt_addr_t;
  typedef logic [BankAddrWidth-1:0] bank_addr_t;
  typedef logic [MetaIdWidth-1:0]   meta_id_t;
  typedef logic [CoreIdWidth-1:0]   core_id_t;
  typedef logic [IniAddrWidth-1:0]  ini_addr_t;
  typedef logic [AmoWidth-1:0]      amo_t;

  localparam amo_t AmoLR = 4'hA;
  localparam amo_t AmoSC = 4'hB;

  typedef struct packed {
    amo_t  amo;
    data_t data;
  } tcdm_payload_t;

  typedef struct packed {
    meta_id_t      meta_id;
    ini_addr_t     ini_addr;
    core_id_t      core_id;
    tgt_addr_t     tgt_addr;
    logic          wen;
    tcdm_payload_t wdata;
    strb_t         be;
  } tcdm_slave_req_t;

  typedef struct packed {
    meta_id_t      meta_id;
    ini_addr_t     ini_addr;
    core_id_t      core_id;
    tcdm_payload_t rdata;
  } tcdm_slave_resp_t;

endpackage

`default_nettype wire

// File: rtl/fifo_v3.sv
// +--------------------------------------------------------------------------+
// | fifo_v3: parametric FIFO with optional fall-through (empty push bypass). |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned CNT_WIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CNT_WIDTH-1:0] usage_o,
  input  dtype                 data_i,
  input  logic                 push_i,
  output dtype                 data_o,
  input  logic                 pop_i
);

  dtype                  mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  is_empty, push, pop, bypass;

  assign is_empty = (cnt_q == '0);
  assign full_o   = (cnt_q == CNT_WIDTH'(DEPTH));
  assign empty_o  = is_empty & ~(FALL_THROUGH & push_i);
  assign usage_o  = cnt_q;
  assign data_o   = (FALL_THROUGH && is_empty) ? data_i : mem_q[rd_ptr_q];

  assign push   = push_i & ~full_o;
  assign pop    = pop_i & ~empty_o;
  // In fall-through mode a same-cycle push/pop on an empty FIFO never touches storage.
  assign bypass = FALL_THROUGH & is_empty & push & pop;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else if (!bypass) begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !bypass && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tcdm_bank_responder.sv
// +--------------------------------------------------------------------------+
// | tcdm_bank_responder: TCDM request -> SRAM bank command, ordered replies. |
// | Optional LR/SC reservation enabled by macro TCDM_LRSC_EN. Rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module tcdm_bank_responder
  import mempool_pkg::*;
#(
  parameter int unsigned RespDepth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  tcdm_slave_req_t  req_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output tcdm_slave_resp_t resp_o,
  output logic             bank_req_o,
  output logic             bank_we_o,
  output bank_addr_t       bank_addr_o,
  output data_t            bank_wdata_o,
  output strb_t            bank_be_o,
  input  data_t            bank_rdata_i
);

  localparam int unsigned CntWidth = $clog2(RespDepth + 1);

  logic                is_wr, is_sc, has_resp, sc_ok, accept, pop, full, empty;
  logic [CntWidth-1:0] usage;
  logic [CntWidth:0]   pending;
  tcdm_slave_resp_t    fifo_in;
  logic                unused_bits;

  logic             infl_q, infl_d, infl_rd_q, infl_rd_d;
  tcdm_slave_resp_t infl_resp_q, infl_resp_d;

  assign is_sc    = (req_i.wdata.amo == AmoSC);
  assign is_wr    = req_i.wen & (req_i.wdata.amo == '0);
  assign has_resp = ~is_wr;

  // Ready accounts for a pop happening this very cycle.
  assign pop         = resp_valid_o & resp_ready_i;
  assign pending     = {1'b0, usage} + {{CntWidth{1'b0}}, infl_q} - {{CntWidth{1'b0}}, pop};
  assign req_ready_o = (pending < (CntWidth + 1)'(RespDepth));
  assign accept      = req_valid_i & req_ready_o;

  assign bank_req_o   = accept;
  assign bank_we_o    = accept & (is_wr | (is_sc & sc_ok));
  assign bank_addr_o  = req_i.tgt_addr[TgtAddrWidth-1:BankIdxWidth];
  assign bank_wdata_o = req_i.wdata.data;
  assign bank_be_o    = req_i.be;

`ifdef TCDM_LRSC_EN
  logic       is_lr;
  logic       res_valid_q, res_valid_d;
  bank_addr_t res_addr_q, res_addr_d;
  ini_addr_t  res_ini_q, res_ini_d;
  core_id_t   res_core_q, res_core_d;

  assign is_lr = (req_i.wdata.amo == AmoLR);
  assign sc_ok = res_valid_q & (res_addr_q == bank_addr_o) &
                 (res_ini_q == req_i.ini_addr) & (res_core_q == req_i.core_id);

  always_comb begin
    res_valid_d = res_valid_q;
    res_addr_d  = res_addr_q;
    res_ini_d   = res_ini_q;
    res_core_d  = res_core_q;
    if (accept) begin
      if (is_lr) begin
        res_valid_d = 1'b1;
        res_addr_d  = bank_addr_o;
        res_ini_d   = req_i.ini_addr;
        res_core_d  = req_i.core_id;
      end else if ((is_wr && res_addr_q == bank_addr_o) || (is_sc && sc_ok)) begin
        res_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
      res_ini_q   <= '0;
      res_core_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_addr_q  <= res_addr_d;
      res_ini_q   <= res_ini_d;
      res_core_q  <= res_core_d;
    end
  end
`else
  assign sc_ok = 1'b1;
`endif

  // Response metadata waits one cycle for the SRAM read data; SC status is fixed at accept.
  always_comb begin
    infl_d      = accept & has_resp;
    infl_rd_d   = infl_rd_q;
    infl_resp_d = infl_resp_q;
    if (accept) begin
      infl_rd_d                 = ~is_sc;
      infl_resp_d.meta_id       = req_i.meta_id;
      infl_resp_d.ini_addr      = req_i.ini_addr;
      infl_resp_d.core_id       = req_i.core_id;
      infl_resp_d.rdata.amo     = req_i.wdata.amo;
      infl_resp_d.rdata.data    = {{(DataWidth - 1){1'b0}}, ~sc_ok};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      infl_q      <= 1'b0;
      infl_rd_q   <= 1'b0;
      infl_resp_q <= '0;
    end else begin
      infl_q      <= infl_d;
      infl_rd_q   <= infl_rd_d;
      infl_resp_q <= infl_resp_d;
    end
  end

  always_comb begin
    fifo_in = infl_resp_q;
    if (infl_rd_q) begin
      fifo_in.rdata.data = bank_rdata_i;
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b1),
    .DATA_WIDTH   ($bits(tcdm_slave_resp_t)),
    .DEPTH        (RespDepth),
    .dtype        (tcdm_slave_resp_t)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (usage),
    .data_i  (fifo_in),
    .push_i  (infl_q),
    .data_o  (resp_o),
    .pop_i   (pop)
  );

  assign resp_valid_o = ~empty;

  assign unused_bits = ^{req_i.tgt_addr[BankIdxWidth-1:0], full};

endmodule

`default_nettype wire

// File: tb/tb_tcdm_bank_responder.sv
// +--------------------------------------------------------------------------+
// | tb_tcdm_bank_responder: directed self-checking bench with an SRAM model. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_tcdm_bank_responder;
  import mempool_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  tcdm_slave_req_t  req = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  tcdm_slave_resp_t resp;
  logic             bank_req, bank_we;
  bank_addr_t       bank_addr;
  data_t            bank_wdata, bank_rdata;
  strb_t            bank_be;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tcdm_bank_responder #(.RespDepth(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_i        (req),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_o       (resp),
    .bank_req_o   (bank_req),
    .bank_we_o    (bank_we),
    .bank_addr_o  (bank_addr),
    .bank_wdata_o (bank_wdata),
    .bank_be_o    (bank_be),
    .bank_rdata_i (bank_rdata)
  );

  // SRAM model: unwritten words read as 0x1000_0000 | bank address.
  bit [255:0] wr_vld;
  data_t      mem [256];
  data_t      rdata_q = '0;
  assign bank_rdata = rdata_q;

  function automatic data_t word(input bank_addr_t a);
    return wr_vld[a] ? mem[a] : (32'h1000_0000 | 32'(a));
  endfunction

  function automatic data_t merge(input data_t old, input data_t wd, input strb_t be);
    data_t r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (bank_req) begin
      if (bank_we) begin
        mem[bank_addr]    <= merge(word(bank_addr), bank_wdata, bank_be);
        wr_vld[bank_addr] <= 1'b1;
      end else begin
        rdata_q <= word(bank_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic wen, input amo_t amo, input tgt_addr_t addr, input ini_addr_t ini,
                      input core_id_t core, input meta_id_t meta, input data_t data, input strb_t be);
    req_valid        = 1'b1;
    req.wen          = wen;
    req.wdata.amo    = amo;
    req.tgt_addr     = addr;
    req.ini_addr     = ini;
    req.core_id      = core;
    req.meta_id      = meta;
    req.wdata.data   = data;
    req.be           = be;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req       = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    mid();
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_bank_req", bank_req, 0);
    rst_n = 1'b1;
    mid();
    chk("rst_req_ready", req_ready, 1);

    // Single read, latency 1
    next(); resp_ready = 1'b1; send(0, 4'h0, 12'h010, 4'd3, 4'd1, 8'd5, 32'h0, 4'h0); mid();
    chk("rd_ready", req_ready, 1);
    chk("rd_bank_req", bank_req, 1);
    chk("rd_bank_we", bank_we, 0);
    chk("rd_bank_addr", bank_addr, 32'h1);
    next(); idle(); mid();
    chk("rd_resp_valid", resp_valid, 1);
    chk("rd_data", resp.rdata.data, 32'h1000_0001);
    chk("rd_ini", resp.ini_addr, 3);
    chk("rd_core", resp.core_id, 1);
    chk("rd_meta", resp.meta_id, 5);
    next(); mid();
    chk("rd_done", resp_valid, 0);

    // Plain writes: no response, readback
    next(); send(1, 4'h0, 12'h020, 4'd0, 4'd2, 8'd7, 32'hDEAD_BEEF, 4'hF); mid();
    chk("wr_bank_req", bank_req, 1);
    chk("wr_bank_we", bank_we, 1);
    chk("wr_wdata", bank_wdata, 32'hDEAD_BEEF);
    chk("wr_be", bank_be, 4'hF);
    chk("wr_addr", bank_addr, 32'h2);
    next(); send(1, 4'h0, 12'h030, 4'd0, 4'd2, 8'd8, 32'h0000_1234, 4'h3); mid();
    chk("wr_no_resp0", resp_valid, 0);
    next(); send(0, 4'h0, 12'h020, 4'd1, 4'd2, 8'd9, 32'h0, 4'h0); mid();
    chk("wr_no_resp1", resp_valid, 0);
    next(); send(0, 4'h0, 12'h030, 4'd1, 4'd2, 8'd10, 32'h0, 4'h0); mid();
    chk("wr_rb_data", resp.rdata.data, 32'hDEAD_BEEF);
    chk("wr_rb_meta", resp.meta_id, 9);
    next(); idle(); mid();
    chk("wr_partial", resp.rdata.data, 32'h1000_1234);

    // Backpressure with RespDepth=2
    next(); resp_ready = 1'b0; mid();
    next(); send(0, 4'h0, 12'h040, 4'd2, 4'd0, 8'd20, 32'h0, 4'h0); mid();
    chk("bp_rdy0", req_ready, 1);
    next(); send(0, 4'h0, 12'h050, 4'd2, 4'd0, 8'd21, 32'h0, 4'h0); mid();
    chk("bp_rdy1", req_ready, 1);
    next(); send(0, 4'h0, 12'h060, 4'd2, 4'd0, 8'd22, 32'h0, 4'h0); mid();
    chk("bp_rdy2", req_ready, 0);
    chk("bp_head_meta", resp.meta_id, 20);
    next(); mid();
    chk("bp_rdy3", req_ready, 0);
    chk("bp_head_hold", resp.rdata.data, 32'h1000_0004);
    next(); resp_ready = 1'b1; mid();
    chk("bp_rdy4", req_ready, 1);
    chk("bp_r0_meta", resp.meta_id, 20);
    next(); send(0, 4'h0, 12'h070, 4'd2, 4'd0, 8'd23, 32'h0, 4'h0); mid();
    chk("bp_rdy5", req_ready, 1);
    chk("bp_r1_meta", resp.meta_id, 21);
    chk("bp_r1_data", resp.rdata.data, 32'h1000_0005);
    next(); idle(); mid();
    chk("bp_r2_meta", resp.meta_id, 22);
    chk("bp_r2_data", resp.rdata.data, 32'h1000_0006);
    next(); mid();
    chk("bp_r3_meta", resp.meta_id, 23);
    chk("bp_r3_data", resp.rdata.data, 32'h1000_0007);
    next(); mid();
    chk("bp_empty", resp_valid, 0);

`ifdef TCDM_LRSC_EN
    // LR then SC succeeds once
    next(); send(1, AmoLR, 12'h0A0, 4'd0, 4'd0, 8'd30, 32'h0, 4'hF); mid();
    chk("lr_we", bank_we, 0);
    next(); send(1, AmoSC, 12'h0A0, 4'd0, 4'd0, 8'd31, 32'hCAFE_0001, 4'hF); mid();
    chk("lr_data", resp.rdata.data, 32'h1000_000A);
    chk("lr_amo", resp.rdata.amo, 32'(AmoLR));
    chk("sc_ok_we", bank_we, 1);
    next(); send(1, AmoSC, 12'h0A0, 4'd0, 4'd0, 8'd32, 32'h0BAD_0002, 4'hF); mid();
    chk("sc_ok_data", resp.rdata.data, 0);
    chk("sc_rep_we", bank_we, 0);
    next(); send(0, 4'h0, 12'h0A0, 4'd0, 4'd0, 8'd33, 32'h0, 4'h0); mid();
    chk("sc_rep_data", resp.rdata.data, 1);
    next(); idle(); mid();
    chk("sc_mem", resp.rdata.data, 32'hCAFE_0001);
    // Intervening write kills reservation; SC without LR fails
    next(); send(1, AmoLR, 12'h0A0, 4'd0, 4'd0, 8'd34, 32'h0, 4'hF); mid();
    next(); send(1, 4'h0, 12'h0A0, 4'd0, 4'd1, 8'd35, 32'h1111_1111, 4'hF); mid();
    chk("lr2_data", resp.rdata.data, 32'hCAFE_0001);
    next(); send(1, AmoSC, 12'h0A0, 4'd0, 4'd0, 8'd36, 32'h2222_2222, 4'hF); mid();
    chk("sc_wr_we", bank_we, 0);
    next(); send(1, AmoSC, 12'h0B0, 4'd1, 4'd2, 8'd37, 32'h3333_3333, 4'hF); mid();
    chk("sc_wr_data", resp.rdata.data, 1);
    chk("sc_nolr_we", bank_we, 0);
    next(); send(0, 4'h0, 12'h0A0, 4'd0, 4'd0, 8'd38, 32'h0, 4'h0); mid();
    chk("sc_nolr_data", resp.rdata.data, 1);
    chk("sc_nolr_meta", resp.meta_id, 37);
    next(); idle(); mid();
    chk("sc_wr_mem", resp.rdata.data, 32'h1111_1111);
`else
    // No reservation: LR is a read, SC always writes and returns 0
    next(); send(1, AmoLR, 12'h0A0, 4'd0, 4'd0, 8'd30, 32'h0, 4'hF); mid();
    chk("lr_we", bank_we, 0);
    next(); send(1, AmoSC, 12'h0A0, 4'd0, 4'd0, 8'd31, 32'hCAFE_0001, 4'hF); mid();
    chk("lr_data", resp.rdata.data, 32'h1000_000A);
    chk("lr_amo", resp.rdata.amo, 32'(AmoLR));
    chk("sc_we", bank_we, 1);
    next(); send(1, AmoSC, 12'h0A0, 4'd0, 4'd0, 8'd32, 32'h0BAD_0002, 4'hF); mid();
    chk("sc_data", resp.rdata.data, 0);
    chk("sc2_we", bank_we, 1);
    next(); send(0, 4'h0, 12'h0A0, 4'd0, 4'd0, 8'd33, 32'h0, 4'h0); mid();
    chk("sc2_data", resp.rdata.data, 0);
    next(); idle(); mid();
    chk("sc_mem", resp.rdata.data, 32'h0BAD_0002);
`endif

    // Reset with two buffered responses
    next(); resp_ready = 1'b0; send(0, 4'h0, 12'h010, 4'd0, 4'd0, 8'd40, 32'h0, 4'h0); mid();
    next(); send(0, 4'h0, 12'h020, 4'd0, 4'd0, 8'd41, 32'h0, 4'h0); mid();
    next(); idle(); mid();
    chk("rs_full_ready", req_ready, 0);
    chk("rs_valid", resp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_async_valid", resp_valid, 0);
    next(); mid();
    rst_n = 1'b1;
    resp_ready = 1'b1;
    next(); mid();
    chk("rs_post_valid", resp_valid, 0);
    chk("rs_post_ready", req_ready, 1);
    next(); mid();
    chk("rs_post_valid2", resp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tcdm_bank_responder.md
TCDM_BANK_RESPONDER -- requirements
Module: tcdm_bank_responder

Interface
REQ-001 SHALL have parameter RespDepth, default 2, response buffer depth in entries (>=1).
REQ-002 SHALL have ports: clk_i  in  1  single clock, all logic rising-edge.
REQ-003 SHALL have ports: rst_ni  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req_valid_i  in  1; req_ready_o  out  1; req_i  in  tcdm_slave_req_t  tile-side request.
REQ-005 SHALL have ports: resp_valid_o  out  1; resp_ready_i  in  1; resp_o  out  tcdm_slave_resp_t  response to initiator.
REQ-006 SHALL have ports: bank_req_o  out  1; bank_we_o  out  1; bank_addr_o  out  bank_addr_t; bank_wdata_o  out  data_t; bank_be_o  out  strb_t  SRAM command.
REQ-007 SHALL have ports: bank_rdata_i  in  data_t  SRAM read data, valid one cycle after bank_req_o with bank_we_o=0.

Function
REQ-008 Request accepted on req_valid_i & req_ready_o; accepted request drives bank_req_o=1 combinationally in the same cycle.
REQ-009 bank_addr_o = req_i.tgt_addr with the low idx_width(NumBanksPerTile) bits (bank interleave index) dropped; bank_wdata_o = req_i.wdata.data; bank_be_o = req_i.be.
REQ-010 Classification: read = wen 0; plain write = wen 1, amo 0; LR = amo AmoLR; SC = amo AmoSC; other nonzero amo treated as read.
REQ-011 Plain writes produce no response; reads, LR, SC each produce exactly one response.
REQ-012 Response echoes meta_id, core_id, amo of the request and ini_addr; rdata.data = bank_rdata_i for read/LR, SC status for SC.
REQ-013 Flow control: req_ready_o = (buffer occupancy + in-flight responses) < RespDepth; plain writes accepted whenever ready regardless of kind.
REQ-014 Response buffer is fall-through: request accepted in cycle N, response visible on resp_valid_o in cycle N+1 when buffer empty; minimum latency 1 cycle.
REQ-015 resp_valid_o, resp_o held stable while resp_valid_o & !resp_ready_i; responses returned strictly in acceptance order.
REQ-016 Simultaneous push and pop when full SHALL not be permitted by construction of REQ-013; pop and new acceptance in same cycle allowed at occupancy RespDepth-1 only if the pop frees the slot (ready includes current-cycle pop).
REQ-017 In-flight tracking: 1-bit register set on accepted response-producing request, cleared next cycle when data enters buffer.

Reset
REQ-018 On rst_ni low: buffer empty, in-flight cleared, reservation invalid; resp_valid_o=0, bank_req_o=0, req_ready_o=1 after reset release.
REQ-019 Reset mid-operation SHALL discard in-flight reads and buffered responses; no response emitted after release for pre-reset requests.

Configuration
REQ-020 Macro TCDM_LRSC_EN defined: single reservation register {valid, bank address, ini_addr, core_id}; LR reads and sets it; SC succeeds iff valid and all fields match, then writes and returns 0; failing SC does not write, returns 1.
REQ-021 With TCDM_LRSC_EN: any plain write or successful SC to the reserved address clears the reservation; a new LR overwrites it.
REQ-022 Without TCDM_LRSC_EN: no reservation state; LR behaves as read; SC is an unconditional write returning 0.

Structure
REQ-023 Constants AmoLR, AmoSC (amo_t) SHALL live in mempool_pkg next to tcdm_slave_req_t/resp_t; no new typedefs local to the module.
REQ-024 Response buffer SHALL be one sub-module instance, fifo_v3 (common_cells), FALL_THROUGH=1, DEPTH=RespDepth.

Verification
REQ-025 Read addr 0x10 ini 3 core 1 meta 5, resp_ready_i=1 -> resp_valid_o at N+1, data = SRAM word, ini 3, core 1, meta 5.
REQ-026 Back-to-back 4 reads, resp_ready_i=0, RespDepth=2 -> req_ready_o drops after 2 accepted; releasing ready returns 4 responses in order.
REQ-027 Plain write 0xDEADBEEF be 0xF -> bank_we_o=1 same cycle, no response; subsequent read returns 0xDEADBEEF.
REQ-028 TCDM_LRSC_EN: LR addr A (ini 0 core 0), SC A same ids -> SC data 0, memory written; repeat SC -> data 1, no write.
REQ-029 TCDM_LRSC_EN: LR A core 0, plain write A core 1, SC A core 0 -> data 1; SC from core 2 without LR -> data 1.
REQ-030 Assert rst_ni low with 2 buffered responses -> resp_valid_o=0 immediately; after release no stale response, req_ready_o=1.
